// File: rtl/sum_diff_decoder.sv
// Sum/difference decoder: recovers A=(S+D)/2 and B=(S-D)/2 through a 2-stage pipeline,
// flags odd or out-of-range pairs, counts errors and block-averages the recovered channels.
module sum_diff_decoder #(
  parameter int DATA_W   = 16,
  parameter int LOG2_AVG = 4,
  parameter int ERR_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W:0]   in_sum_i,
  input  logic [DATA_W:0]   in_diff_i,
  input  logic              in_valid_i,
  input  logic              avg_enable_i,
  input  logic              restart_i,
  input  logic              clear_err_i,
  output logic [DATA_W-1:0] out_a_o,
  output logic [DATA_W-1:0] out_b_o,
  output logic              out_valid_o,
  output logic              out_err_o,
  output logic [DATA_W-1:0] avg_a_o,
  output logic [DATA_W-1:0] avg_b_o,
  output logic              avg_valid_o,
  output logic [ERR_W-1:0]  err_count_o
);
  localparam int PW = DATA_W + 2;
  localparam int AW = DATA_W + LOG2_AVG;

  typedef enum logic {IDLE, ACCUM} avg_state_e;

  logic [PW-1:0]     sum_ext, diff_ext;
  logic [PW-1:0]     p_q, m_q;
  logic              v1_q;
  logic              sat_a, sat_b;
  logic [DATA_W-1:0] a_d, b_d;
  logic [DATA_W-1:0] out_a_q, out_b_q;
  logic              out_valid_q, out_err_q;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

  avg_state_e        state_q, state_d;
  logic [AW-1:0]     acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic [AW-1:0]     sample_a, sample_b, sum_a, sum_b;
  logic [LOG2_AVG-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] avg_a_q, avg_a_d, avg_b_q, avg_b_d;
  logic              avg_valid_q, avg_valid_d;

  assign sum_ext  = {in_sum_i[DATA_W], in_sum_i};
  assign diff_ext = {in_diff_i[DATA_W], in_diff_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_q  <= '0;
      m_q  <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= in_valid_i;
      if (in_valid_i) begin
        p_q <= sum_ext + diff_ext;
        m_q <= sum_ext - diff_ext;
      end
    end
  end

  // Dropping bit 0 of P/M is the floor halving; the result fits DATA_W bits
  // only when its top two bits agree, otherwise clamp toward the sign.
  always_comb begin
    sat_a = p_q[PW-1] != p_q[PW-2];
    sat_b = m_q[PW-1] != m_q[PW-2];
    a_d   = sat_a ? {p_q[PW-1], {(DATA_W-1){~p_q[PW-1]}}} : p_q[DATA_W:1];
    b_d   = sat_b ? {m_q[PW-1], {(DATA_W-1){~m_q[PW-1]}}} : m_q[DATA_W:1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= v1_q;
      if (v1_q) begin
        out_a_q   <= a_d;
        out_b_q   <= b_d;
        // S+D and S-D always share parity
        out_err_q <= p_q[0] | m_q[0] | sat_a | sat_b;
      end
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clear_err_i)
      err_cnt_d = '0;
    else if (out_valid_q && out_err_q && !(&err_cnt_q))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  assign sample_a = {{LOG2_AVG{out_a_q[DATA_W-1]}}, out_a_q};
  assign sample_b = {{LOG2_AVG{out_b_q[DATA_W-1]}}, out_b_q};
  assign sum_a    = acc_a_q + sample_a;
  assign sum_b    = acc_b_q + sample_b;

  always_comb begin
    state_d     = state_q;
    acc_a_d     = acc_a_q;
    acc_b_d     = acc_b_q;
    cnt_d       = cnt_q;
    avg_a_d     = avg_a_q;
    avg_b_d     = avg_b_q;
    avg_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        acc_a_d = '0;
        acc_b_d = '0;
        cnt_d   = '0;
        if (avg_enable_i) state_d = ACCUM;
      end
      ACCUM: begin
        if (!avg_enable_i) begin
          state_d = IDLE;
          acc_a_d = '0;
          acc_b_d = '0;
          cnt_d   = '0;
        end else if (restart_i) begin
          acc_a_d = out_valid_q ? sample_a : '0;
          acc_b_d = out_valid_q ? sample_b : '0;
          cnt_d   = out_valid_q ? LOG2_AVG'(1) : '0;
        end else if (out_valid_q) begin
          if (&cnt_q) begin
            // Upper DATA_W bits of the total are the floor mean of the window
            avg_a_d     = sum_a[AW-1:LOG2_AVG];
            avg_b_d     = sum_b[AW-1:LOG2_AVG];
            avg_valid_d = 1'b1;
            acc_a_d     = '0;
            acc_b_d     = '0;
            cnt_d       = '0;
          end else begin
            acc_a_d = sum_a;
            acc_b_d = sum_b;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      cnt_q       <= '0;
      avg_a_q     <= '0;
      avg_b_q     <= '0;
      avg_valid_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_a_q     <= acc_a_d;
      acc_b_q     <= acc_b_d;
      cnt_q       <= cnt_d;
      avg_a_q     <= avg_a_d;
      avg_b_q     <= avg_b_d;
      avg_valid_q <= avg_valid_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_a_o     = out_a_q;
  assign out_b_o     = out_b_q;
  assign out_valid_o = out_valid_q;
  assign out_err_o   = out_err_q;
  assign avg_a_o     = avg_a_q;
  assign avg_b_o     = avg_b_q;
  assign avg_valid_o = avg_valid_q;
  assign err_count_o = err_cnt_q;
endmodule

// File: tb/tb_sum_diff_decoder.sv
// Bench for sum_diff_decoder: integer reference model checked every cycle, plus
// directed literal expectations for decode, saturation, averaging, error count and reset.
module tb_sum_diff_decoder;
  localparam int DW = 16;
  localparam int L = 2;
  localparam int EW = 4;
  localparam int N = 1 << L;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW:0] in_sum = '0, in_diff = '0;
  logic in_valid = 1'b0, avg_en = 1'b0, restart = 1'b0, clr = 1'b0;
  logic [DW-1:0] out_a, out_b, avg_a, avg_b;
  logic out_valid, out_err, avg_valid;
  logic [EW-1:0] err_count;

  always #5 clk = ~clk;

  sum_diff_decoder #(.DATA_W(DW), .LOG2_AVG(L), .ERR_W(EW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_sum_i(in_sum), .in_diff_i(in_diff),
    .in_valid_i(in_valid), .avg_enable_i(avg_en), .restart_i(restart),
    .clear_err_i(clr), .out_a_o(out_a), .out_b_o(out_b), .out_valid_o(out_valid),
    .out_err_o(out_err), .avg_a_o(avg_a), .avg_b_o(avg_b), .avg_valid_o(avg_valid),
    .err_count_o(err_count));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic longint fdiv(input longint x, input longint n);
    longint q = x / n;
    if ((x % n != 0) && (x < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp(input longint x);
    longint hi = (longint'(1) << (DW - 1)) - 1;
    if (x > hi) return hi;
    if (x < -hi - 1) return -hi - 1;
    return x;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {int due; longint a; longint b; bit err;} pend_t;
  pend_t pq[$];
  longint win_a[$], win_b[$];
  int cyc;
  bit m_v, m_err, m_act, m_avg_v;
  longint m_a, m_b, m_avg_a, m_avg_b;
  int m_ecnt;

  task automatic model_clear();
    pq.delete(); win_a.delete(); win_b.delete();
    m_v = 0; m_err = 0; m_act = 0; m_avg_v = 0;
    m_a = 0; m_b = 0; m_avg_a = 0; m_avg_b = 0; m_ecnt = 0;
  endtask

  task automatic model_step();
    bit pv = m_v;
    bit pe = m_err;
    longint pa = m_a, pb = m_b;
    longint s, d, p, m, a, b, sa, sb;
    pend_t e;
    m_avg_v = 0;
    if (m_act && avg_en) begin
      if (restart) begin
        win_a.delete(); win_b.delete();
        if (pv) begin win_a.push_back(pa); win_b.push_back(pb); end
      end else if (pv) begin
        win_a.push_back(pa); win_b.push_back(pb);
        if (win_a.size() == N) begin
          sa = 0; sb = 0;
          foreach (win_a[i]) begin sa += win_a[i]; sb += win_b[i]; end
          m_avg_a = fdiv(sa, N); m_avg_b = fdiv(sb, N); m_avg_v = 1;
          win_a.delete(); win_b.delete();
        end
      end
    end else begin
      win_a.delete(); win_b.delete();
    end
    m_act = avg_en;
    if (clr) m_ecnt = 0;
    else if (pv && pe && m_ecnt < ERR_MAX) m_ecnt++;
    cyc++;
    m_v = 0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      m_v = 1; m_a = pq[0].a; m_b = pq[0].b; m_err = pq[0].err;
      void'(pq.pop_front());
    end
    if (in_valid) begin
      s = longint'($signed(in_sum)); d = longint'($signed(in_diff));
      p = s + d; m = s - d;
      a = fdiv(p, 2); b = fdiv(m, 2);
      e.due = cyc + 1; e.a = clamp(a); e.b = clamp(b);
      e.err = (p % 2 != 0) || (e.a != a) || (e.b != b);
      pq.push_back(e);
    end
  endtask

  initial begin
    cyc = 0;
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_clear();
      else model_step();
    end
  end

  int avg_pulses = 0;
  initial forever begin
    @(negedge clk);
    chk("out_valid", out_valid, m_v);
    chk("out_a", $signed(out_a), m_a);
    chk("out_b", $signed(out_b), m_b);
    chk("out_err", out_err, m_err);
    chk("avg_valid", avg_valid, m_avg_v);
    chk("avg_a", $signed(avg_a), m_avg_a);
    chk("avg_b", $signed(avg_b), m_avg_b);
    chk("err_count", err_count, m_ecnt);
    if (avg_valid) avg_pulses++;
  end

  // ---------------- stimulus helpers (always entered at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input longint s, input longint d);
    logic [63:0] sv, dv;
    sv = s; dv = d;
    in_sum = sv[DW:0]; in_diff = dv[DW:0]; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_ab(input longint a, input longint b);
    send(a + b, a - b);
  endtask

  task automatic wait_out(input string name);
    bit seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(posedge clk); #1;
      seen = out_valid;
    end
    if (!seen) chk({name, "_timeout"}, 0, 1);
  endtask

  longint ea[8], eb[8];
  int got, first_i, last_i, np, pc[4], base;
  longint pa0, pb0;

  initial begin
    idle(3);
    rst_n = 1'b1;
    idle(1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_avg_a", $signed(avg_a), 0);

    // basic decode
    send(300, 100); wait_out("t1");
    chk("t1_a", $signed(out_a), 200); chk("t1_b", $signed(out_b), 100); chk("t1_err", out_err, 0);
    idle(1); chk("t1_strobe_once", out_valid, 0);
    send(-65536, 0); wait_out("t2a");
    chk("t2_min_a", $signed(out_a), -32768); chk("t2_min_b", $signed(out_b), -32768);
    chk("t2_min_err", out_err, 0);
    send(3, 0); wait_out("t2b");
    chk("t2_odd_a", $signed(out_a), 1); chk("t2_odd_b", $signed(out_b), 1); chk("t2_odd_err", out_err, 1);
    idle(1); chk("t2_errcount", err_count, 1);
    send(65535, -65535); wait_out("t3");
    chk("t3_sat_a", $signed(out_a), 0); chk("t3_sat_b", $signed(out_b), 32767); chk("t3_sat_err", out_err, 1);

    // 8 back-to-back samples, order and continuity
    for (int i = 0; i < 8; i++) begin
      ea[i] = longint'($urandom_range(0, 65535)) - 32768;
      eb[i] = longint'($urandom_range(0, 65535)) - 32768;
    end
    got = 0; first_i = -1; last_i = -1;
    fork
      for (int i = 0; i < 8; i++) send_ab(ea[i], eb[i]);
      for (int k = 1; k <= 14; k++) begin
        @(posedge clk); #1;
        if (out_valid) begin
          if (got < 8) begin
            chk("b2b_a", $signed(out_a), ea[got]); chk("b2b_b", $signed(out_b), eb[got]);
          end
          if (first_i < 0) first_i = k;
          last_i = k; got++;
        end
      end
    join
    chk("b2b_count", got, 8);
    chk("b2b_span", last_i - first_i, 7);

    // averaging: two windows without gap
    avg_en = 1'b1; idle(1);
    np = 0;
    fork
      begin
        send_ab(4, -1); send_ab(8, -1); send_ab(12, -1); send_ab(16, -1);
        for (int i = 0; i < 4; i++) send_ab(longint'($urandom_range(0, 2000)) - 1000, 5);
      end
      for (int k = 1; k <= 14; k++) begin
        @(posedge clk); #1;
        if (avg_valid) begin
          if (np == 0) begin pa0 = $signed(avg_a); pb0 = $signed(avg_b); end
          if (np < 4) pc[np] = k;
          np++;
        end
      end
    join
    chk("avg_pulses", np, 2);
    chk("avg_first_cycle", pc[0], 6);
    chk("avg_gap", pc[1] - pc[0], 4);
    chk("avg_a_first", pa0, 10);
    chk("avg_b_first", pb0, -1);

    // restart coincident with 3rd sample's OutValid
    send_ab(7, 7); send_ab(9, 9); send_ab(100, 1);
    idle(1); restart = 1'b1; idle(1); restart = 1'b0;
    base = avg_pulses;
    send_ab(-7, 2); send_ab(20, 3); idle(3);
    chk("restart_no_avg", avg_pulses - base, 0);
    send_ab(3, -10); idle(3);
    chk("restart_avg_pulse", avg_pulses - base, 1);
    chk("restart_avg_a", $signed(avg_a), 29);
    chk("restart_avg_b", $signed(avg_b), -1);

    // enable dropped mid-window, then fresh window
    base = avg_pulses;
    send_ab(50, 50); send_ab(60, 60); idle(3);
    avg_en = 1'b0; idle(2);
    send_ab(70, 70); send_ab(80, 80); idle(3);
    avg_en = 1'b1; idle(1);
    chk("disable_no_avg", avg_pulses - base, 0);
    send_ab(1, -1); send_ab(2, -2); send_ab(3, -3); send_ab(5, -5); idle(3);
    chk("reenable_pulse", avg_pulses - base, 1);
    chk("reenable_avg_a", $signed(avg_a), 2);
    chk("reenable_avg_b", $signed(avg_b), -3);

    // error counter saturation and clear priority
    for (int i = 0; i < 20; i++) send(3, 0);
    idle(3);
    chk("errcnt_sat", err_count, ERR_MAX);
    send(3, 0); idle(1);
    chk("clr_err_sample", out_err, 1);
    clr = 1'b1; idle(1); clr = 1'b0;
    chk("errcnt_clear_wins", err_count, 0);
    idle(1); chk("errcnt_after_clear", err_count, 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      longint a, b;
      in_valid = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 4) != 0) begin
        a = longint'($urandom_range(0, 65535)) - 32768;
        b = longint'($urandom_range(0, 65535)) - 32768;
        in_sum = 17'(a + b); in_diff = 17'(a - b);
      end else begin
        in_sum = 17'($urandom); in_diff = 17'($urandom);
      end
      if ($urandom_range(0, 99) == 0) avg_en = ~avg_en;
      restart = ($urandom_range(0, 29) == 0);
      clr = ($urandom_range(0, 99) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; restart = 1'b0; clr = 1'b0; avg_en = 1'b1;
    idle(2);

    // async reset mid-window with samples in flight
    send_ab(11, 3); send_ab(12, 4); send(5, 0);
    rst_n = 1'b0; #1;
    chk("rst_async_out_a", $signed(out_a), 0);
    chk("rst_async_out_valid", out_valid, 0);
    chk("rst_async_avg_a", $signed(avg_a), 0);
    chk("rst_async_errcnt", err_count, 0);
    idle(2);
    rst_n = 1'b1;
    base = avg_pulses; got = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (out_valid) got++;
    end
    chk("post_rst_no_outvalid", got, 0);
    chk("post_rst_no_avg", avg_pulses - base, 0);
    send(-40, 10); wait_out("post_rst");
    chk("post_rst_a", $signed(out_a), -15); chk("post_rst_b", $signed(out_b), -25);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
